// File: rtl/rv32i_alu_if.sv
// Operand/opcode bundle and result bundle for the RV32I ALU.
// The master drives opcode and operands; the slave returns results.
interface rv32i_alu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALU_Operation;
    logic [WIDTH-1:0] Data1;
    logic [WIDTH-1:0] Data2;
    logic [WIDTH-1:0] ALU_result;
    logic             ZERO;
    logic [WIDTH-1:0] ALU_result_q;
    logic             ZERO_q;

    modport master (
        output ALU_Operation,
        output Data1,
        output Data2,
        input  ALU_result,
        input  ZERO,
        input  ALU_result_q,
        input  ZERO_q
    );

    modport slave (
        input  ALU_Operation,
        input  Data1,
        input  Data2,
        output ALU_result,
        output ZERO,
        output ALU_result_q,
        output ZERO_q
    );
endinterface

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result and equality flag,
// plus one-cycle registered copies of both.
module rv32i_alu #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    rv32i_alu_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] res;
    logic             eq;

    assign a     = bus.Data1;
    assign b     = bus.Data2;
    assign shamt = b[4:0];

    // Equality is taken from the operands, not the result,
    // so branches work for every opcode.
    assign eq = (a == b);

    always_comb begin
        res = '0;
        case (bus.ALU_Operation)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a + b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SUB:  res = a - b;
            OP_SRA:  res = $signed(a) >>> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}},
                            ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: res = '0;
        endcase
    end

    assign bus.ALU_result = res;
    assign bus.ZERO       = eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ALU_result_q <= '0;
            bus.ZERO_q       <= 1'b0;
        end else begin
            bus.ALU_result_q <= res;
            bus.ZERO_q       <= eq;
        end
    end
endmodule

// File: tb/tb_rv32i_alu.sv
// Randomized and directed bench for rv32i_alu against an
// arithmetic reference model.
module tb_rv32i_alu;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    rv32i_alu_if bus ();

    rv32i_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint     ua;
        longint     ub;
        longint     sa;
        longint     sb;
        longint     p;
        longint     q;
        logic [63:0] t;
        int         s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b % 32);
        p  = 1;
        for (int i = 0; i < s; i++) p = p * 2;
        t = '0;
        case (op)
            4'd0: t = ua & ub;
            4'd1: t = ua | ub;
            4'd2: t = ua + ub;
            4'd3: t = ua ^ ub;
            4'd4: t = ua * p;
            4'd5: t = ua / p;
            4'd6: t = ua - ub;
            4'd7: begin
                q = sa / p;
                if (sa < 0 && (sa % p) != 0) q = q - 1;
                t = q;
            end
            4'd8: t = (sa < sb) ? 64'd1 : 64'd0;
            4'd9: t = (ua < ub) ? 64'd1 : 64'd0;
            default: t = '0;
        endcase
        return t[31:0];
    endfunction

    task automatic apply(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        bus.ALU_Operation = op;
        bus.Data1 = a;
        bus.Data2 = b;
        #1;
    endtask

    task automatic comb_check(input string tag);
        chk({tag, ".res"}, bus.ALU_result,
            model(bus.ALU_Operation, bus.Data1, bus.Data2));
        chk({tag, ".zero"}, {31'd0, bus.ZERO},
            {31'd0, bus.Data1 == bus.Data2});
    endtask

    initial begin
        logic [3:0]  ops4 [4];
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_z;
        vectors     = 0;
        miscompares = 0;
        ops4[0] = 4'd0;
        ops4[1] = 4'd1;
        ops4[2] = 4'd2;
        ops4[3] = 4'd6;
        rst = 1'b1;
        bus.ALU_Operation = 4'd2;
        bus.Data1 = 32'd1;
        bus.Data2 = 32'd2;

        // reset held two edges, with nonzero live result
        repeat (2) @(posedge clk);
        #1;
        chk("rst.q", bus.ALU_result_q, 32'd0);
        chk("rst.zq", {31'd0, bus.ZERO_q}, 32'd0);
        chk("rst.comb", bus.ALU_result, 32'd3);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("q.add", bus.ALU_result_q, 32'd3);
        chk("q.zq0", {31'd0, bus.ZERO_q}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("q.midrst", bus.ALU_result_q, 32'd0);
        chk("q.midrst.comb", bus.ALU_result, 32'd3);

        @(negedge clk);
        rst = 1'b0;
        bus.Data1 = 32'd5;
        bus.Data2 = 32'd5;
        @(posedge clk);
        #1;
        chk("q.release", bus.ALU_result_q, 32'd10);
        chk("q.zq1", {31'd0, bus.ZERO_q}, 32'd1);

        // directed cases
        apply(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("and", bus.ALU_result, 32'h00F0_1200);
        chk("and.z", {31'd0, bus.ZERO}, 32'd0);
        apply(4'd1, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("or", bus.ALU_result, 32'hFFF0_FF34);
        apply(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("add.wrap", bus.ALU_result, 32'h0000_0001);
        apply(4'd2, 32'h5, 32'h5);
        chk("add.eq", bus.ALU_result, 32'h0000_000A);
        chk("add.eq.z", {31'd0, bus.ZERO}, 32'd1);
        apply(4'd6, 32'h3, 32'h5);
        chk("sub", bus.ALU_result, 32'hFFFF_FFFE);
        apply(4'd6, 32'h8000_0000, 32'h8000_0000);
        chk("sub.eq", bus.ALU_result, 32'd0);
        chk("sub.eq.z", {31'd0, bus.ZERO}, 32'd1);
        apply(4'd7, 32'h8000_0000, 32'h0000_0024);
        chk("sra", bus.ALU_result, 32'hF800_0000);
        apply(4'd5, 32'h8000_0000, 32'h0000_0024);
        chk("srl", bus.ALU_result, 32'h0800_0000);
        apply(4'd4, 32'h8000_0001, 32'hFFFF_FFE0);
        chk("sll.0", bus.ALU_result, 32'h8000_0001);
        apply(4'd4, 32'h0000_0003, 32'h0000_001F);
        chk("sll.31", bus.ALU_result, 32'h8000_0000);
        apply(4'd8, 32'hFFFF_FFFF, 32'h1);
        chk("slt", bus.ALU_result, 32'd1);
        apply(4'd9, 32'hFFFF_FFFF, 32'h1);
        chk("sltu", bus.ALU_result, 32'd0);
        apply(4'd0, 32'h1234_5678, 32'h1234_5678);
        chk("and.eq", bus.ALU_result, 32'h1234_5678);
        chk("and.eq.z", {31'd0, bus.ZERO}, 32'd1);
        apply(4'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("undef", bus.ALU_result, 32'd0);
        chk("undef.z", {31'd0, bus.ZERO}, 32'd1);

        // random core ops
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            apply(ops4[$urandom_range(0, 3)], a, b);
            comb_check("rnd4");
        end

        // random over the whole opcode space
        for (int i = 0; i < 2000; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            apply(op, a, b);
            comb_check("rnd16");
        end

        // registered path with random inputs
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            bus.ALU_Operation = op;
            bus.Data1 = a;
            bus.Data2 = b;
            exp_r = model(op, a, b);
            exp_z = (a == b);
            @(posedge clk);
            #1;
            chk("rndq", bus.ALU_result_q, exp_r);
            chk("rndq.z", {31'd0, bus.ZERO_q}, {31'd0, exp_z});
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
